// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic pipeline-stage register with optional 2-entry skid slot, flush and stall counter.
// Latency: an accepted entry is on out_* right after the capturing falling edge.
// Backpressure: SKID=1 gives a registered in_ready (skid slot free); SKID=0 passes out_ready straight into in_ready.
module pipe_stage_buf #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        count,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Head slot: the entry currently presented downstream.
  logic              r_h_vld;
  logic [DATA_W-1:0] r_h_dat;
  logic [CTRL_W-1:0] r_h_ctl;

  logic [CNT_W-1:0]  r_stall;

  logic w_in_rdy;    // this stage can take a beat at the coming edge
  logic w_in_xfer;   // input beat transfers at the coming edge
  logic w_h_open;    // head is empty or being drained this edge
  logic w_s_vld;     // skid slot occupancy (always 0 without a skid slot)

  assign w_h_open  = ~r_h_vld | out_ready;
  assign w_in_xfer = in_valid & w_in_rdy;

  generate
    if (SKID != 0) begin : g_skid
      // Skid slot: catches a beat accepted while the head is held.
      logic              r_s_vld;
      logic [DATA_W-1:0] r_s_dat;
      logic [CTRL_W-1:0] r_s_ctl;

      // Ready depends only on state, so out_ready never reaches in_ready.
      assign w_in_rdy = ~r_s_vld;
      assign w_s_vld  = r_s_vld;

      // Head refill: skid entry has priority so FIFO order is kept.
      always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
          r_h_vld <= 1'b0;
          r_h_dat <= '0;
          r_h_ctl <= '0;
        end else if (flush) begin
          r_h_vld <= 1'b0;
        end else if (w_h_open) begin
          if (r_s_vld) begin
            r_h_vld <= 1'b1;
            r_h_dat <= r_s_dat;
            r_h_ctl <= r_s_ctl;
          end else if (w_in_xfer) begin
            r_h_vld <= 1'b1;
            r_h_dat <= in_data;
            r_h_ctl <= in_ctrl;
          end else begin
            r_h_vld <= 1'b0;
          end
        end
      end

      // Skid fill/empty: empties whenever the head can take its entry.
      // A beat cannot arrive while the skid is full (in_ready is low),
      // so an open head never has to absorb skid and input together.
      always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
          r_s_vld <= 1'b0;
          r_s_dat <= '0;
          r_s_ctl <= '0;
        end else if (flush) begin
          r_s_vld <= 1'b0;
        end else if (w_h_open) begin
          r_s_vld <= 1'b0;
        end else if (w_in_xfer) begin
          r_s_vld <= 1'b1;
          r_s_dat <= in_data;
          r_s_ctl <= in_ctrl;
        end
      end
    end else begin : g_single
      // Single slot: a draining head can reload in the same edge.
      assign w_in_rdy = ~r_h_vld | out_ready;
      assign w_s_vld  = 1'b0;

      // Head load on transfer, otherwise clear once drained.
      always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
          r_h_vld <= 1'b0;
          r_h_dat <= '0;
          r_h_ctl <= '0;
        end else if (flush) begin
          r_h_vld <= 1'b0;
        end else if (w_in_xfer) begin
          r_h_vld <= 1'b1;
          r_h_dat <= in_data;
          r_h_ctl <= in_ctrl;
        end else if (out_ready) begin
          r_h_vld <= 1'b0;
        end
      end
    end
  endgenerate

  // Stall counter: counts edges where the head is offered but refused, saturating.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_stall <= '0;
    end else if (r_h_vld && !out_ready && (r_stall != {CNT_W{1'b1}})) begin
      r_stall <= r_stall + CNT_W'(1);
    end
  end

  assign in_ready  = w_in_rdy;
  assign out_valid = r_h_vld;
  assign out_data  = r_h_dat;
  assign out_ctrl  = r_h_vld ? r_h_ctl : '0;
  assign count     = {1'b0, r_h_vld} + {1'b0, w_s_vld};
  assign stall_cnt = r_stall;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: three instances (SKID=1, SKID=0, SKID=1 with CNT_W=3) share one stimulus.
// A FIFO-level model predicts every output; directed phases pin key values with literals.
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;

  logic [2:0]        dv, dr;
  logic [2:0][31:0]  dd;
  logic [2:0][7:0]   dc;
  logic [2:0][1:0]   dn;
  logic [15:0]       sc0, sc1;
  logic [2:0]        sc2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(dr[0]), .in_data(in_data),
    .in_ctrl(in_ctrl), .flush(flush), .out_valid(dv[0]), .out_ready(out_ready),
    .out_data(dd[0]), .out_ctrl(dc[0]), .count(dn[0]), .stall_cnt(sc0));

  pipe_stage_buf #(.DATA_W(32), .CTRL_W(8), .SKID(0), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(dr[1]), .in_data(in_data),
    .in_ctrl(in_ctrl), .flush(flush), .out_valid(dv[1]), .out_ready(out_ready),
    .out_data(dd[1]), .out_ctrl(dc[1]), .count(dn[1]), .stall_cnt(sc1));

  pipe_stage_buf #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(3)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(dr[2]), .in_data(in_data),
    .in_ctrl(in_ctrl), .flush(flush), .out_valid(dv[2]), .out_ready(out_ready),
    .out_data(dd[2]), .out_ctrl(dc[2]), .count(dn[2]), .stall_cnt(sc2));

  // ---------------- behavioural model: a bounded FIFO per instance ----------------
  int          m_n[3];
  logic [31:0] m_d[3][2];
  logic [7:0]  m_c[3][2];
  logic [31:0] m_last[3];
  int          m_st[3];
  int          m_skid[3] = '{1, 0, 1};
  int          m_max[3]  = '{65535, 65535, 7};

  function automatic logic m_rdy(int k);
    if (m_skid[k] != 0) return m_n[k] < 2;
    return (m_n[k] == 0) || out_ready;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 3; k++) begin
      m_n[k] = 0;
      m_last[k] = '0;
      m_st[k] = 0;
    end
  endtask

  task automatic m_edge();
    for (int k = 0; k < 3; k++) begin
      logic inx, outx;
      inx  = in_valid && m_rdy(k);
      outx = (m_n[k] > 0) && out_ready;
      if ((m_n[k] > 0) && !out_ready && (m_st[k] < m_max[k])) m_st[k]++;
      if (flush) begin
        m_n[k] = 0;
      end else begin
        if (outx) begin
          m_d[k][0] = m_d[k][1];
          m_c[k][0] = m_c[k][1];
          m_n[k]--;
        end
        if (inx) begin
          m_d[k][m_n[k]] = in_data;
          m_c[k][m_n[k]] = in_ctrl;
          m_n[k]++;
        end
      end
      if (m_n[k] > 0) m_last[k] = m_d[k][0];
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(negedge clk or posedge rst);
      if (rst) m_reset();
      else m_edge();
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] get_sc(int k);
    case (k)
      0:       return 32'(sc0);
      1:       return 32'(sc1);
      default: return 32'(sc2);
    endcase
  endfunction

  // Per-cycle comparison against the model, away from the falling (active) edge.
  initial begin
    forever begin
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("m%0d_out_valid", k), 32'(dv[k]), 32'(m_n[k] > 0));
        chk($sformatf("m%0d_in_ready", k), 32'(dr[k]), 32'(m_rdy(k)));
        chk($sformatf("m%0d_count", k), 32'(dn[k]), 32'(m_n[k]));
        chk($sformatf("m%0d_out_data", k), dd[k], (m_n[k] > 0) ? m_d[k][0] : m_last[k]);
        chk($sformatf("m%0d_out_ctrl", k), 32'(dc[k]), (m_n[k] > 0) ? 32'(m_c[k][0]) : 32'd0);
        chk($sformatf("m%0d_stall_cnt", k), get_sc(k), 32'(m_st[k]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1 rst = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", 32'(dv[0]), 32'd0);
    chk("rst_in_ready", 32'(dr[0]), 32'd1);
    chk("rst_count", 32'(dn[0]), 32'd0);
    chk("rst_out_data", dd[0], 32'd0);
    chk("rst_out_ctrl", 32'(dc[0]), 32'd0);
    chk("rst_stall", 32'(sc0), 32'd0);
    rst = 1'b0;
    tick();

    // Stream four beats with the consumer always ready.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_ctrl   = 8'h05;
    for (int i = 0; i < 4; i++) begin
      in_data = 32'h10 + 32'(i);
      tick();
      chk("stream_data", dd[0], 32'h10 + 32'(i));
      chk("stream_ctrl", 32'(dc[0]), 32'h05);
      chk("stream_count", 32'(dn[0]), 32'd1);
      chk("stream_data_s0", dd[1], 32'h10 + 32'(i));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_idle_valid", 32'(dv[0]), 32'd0);
    chk("stream_idle_ctrl", 32'(dc[0]), 32'd0);
    chk("stream_idle_hold", dd[0], 32'h13);

    // Backpressure fills head then skid.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hAAAA0000;
    tick();
    chk("bp_count1", 32'(dn[0]), 32'd1);
    in_data = 32'hBBBB0000;
    tick();
    chk("bp_count2", 32'(dn[0]), 32'd2);
    chk("bp_in_ready", 32'(dr[0]), 32'd0);
    chk("bp_head_a", dd[0], 32'hAAAA0000);
    chk("bp_s0_head_a", dd[1], 32'hAAAA0000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_head_b", dd[0], 32'hBBBB0000);
    chk("bp_in_ready_back", 32'(dr[0]), 32'd1);
    chk("bp_count_after_a", 32'(dn[0]), 32'd1);
    tick();
    chk("bp_drained", 32'(dn[0]), 32'd0);

    // Flush collides with an incoming beat.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11110000;
    tick();
    in_data = 32'h22220000;
    tick();
    chk("fl_count_full", 32'(dn[0]), 32'd2);
    flush   = 1'b1;
    in_data = 32'hCCCC0000;
    tick();
    chk("fl_count", 32'(dn[0]), 32'd0);
    chk("fl_valid", 32'(dv[0]), 32'd0);
    chk("fl_ctrl", 32'(dc[0]), 32'd0);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("fl_no_c_valid", 32'(dv[0]), 32'd0);
    chk("fl_no_c_data", dd[0], 32'h11110000);

    // Stall counter, including saturation of the narrow instance.
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hEEEE0000;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    chk("stall5", 32'(sc0), 32'd5);
    chk("stall5_narrow", 32'(sc2), 32'd5);
    repeat (5) tick();
    chk("stall10", 32'(sc0), 32'd10);
    chk("stall_sat", 32'(sc2), 32'd7);

    // Asynchronous reset between edges with both slots full.
    in_valid = 1'b1;
    in_data  = 32'hFFFF0000;
    tick();
    chk("ar_count_full", 32'(dn[0]), 32'd2);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("ar_count", 32'(dn[0]), 32'd0);
    chk("ar_valid", 32'(dv[0]), 32'd0);
    chk("ar_data", dd[0], 32'd0);
    chk("ar_in_ready", 32'(dr[0]), 32'd1);
    chk("ar_stall", 32'(sc0), 32'd0);
    rst = 1'b0;
    tick();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = 32'h12340000;
    tick();
    chk("ar_first_beat", dd[0], 32'h12340000);
    chk("ar_first_count", 32'(dn[0]), 32'd1);

    // Single-slot instance: combinational ready from out_ready.
    in_valid = 1'b0;
    tick();
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_data   = 32'h51000001;
    tick();
    in_data = 32'h51000002;
    #1;
    chk("s0_in_ready_low", 32'(dr[1]), 32'd0);
    out_ready = 1'b1;
    #1;
    chk("s0_in_ready_high", 32'(dr[1]), 32'd1);
    tick();
    chk("s0_swap_data", dd[1], 32'h51000002);
    chk("s0_swap_count", 32'(dn[1]), 32'd1);

    // Randomised traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      in_data   = $urandom;
      in_ctrl   = 8'($urandom);
      tick();
    end
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised elastic pipeline-stage register. It is the successor to the fixed-field stage latches between CPU pipeline stages. Payload and control fields are carried as two generic vectors. The block adds a valid/ready handshake, an optional 2-entry skid buffer, flush with bubble insertion, and a stall-cycle counter. It is instantiated between EX and MEM and between other stage pairs.

Parameters:
DATA_W, 32, payload width (PC, ALU result, store data and similar, concatenated by the instantiator)
CTRL_W, 8, control-bit width (MemWr, RegWr, Branch and similar); forced to 0 whenever no valid entry is presented
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
CNT_W, 16, stall counter width

Ports:
clk  in  1  stage clock; all state updates on falling edge, matching the other pipeline registers
rst  in  1  asynchronous reset, active-high
in_valid  in  1  upstream entry valid
in_ready  out  1  block can accept an entry
in_data  in  DATA_W  upstream payload
in_ctrl  in  CTRL_W  upstream control bits
flush  in  1  discard all held entries at the next edge
out_valid  out  1  downstream entry valid
out_ready  in  1  downstream accepts entry
out_data  out  DATA_W  payload of head entry
out_ctrl  out  CTRL_W  control bits of head entry; 0 when out_valid=0
count  out  2  number of held entries (0..2; max 1 when SKID=0)
stall_cnt  out  CNT_W  edges with out_valid=1 and out_ready=0, saturating

Behaviour:
- Reset (rst=1, asynchronous): all entries invalid and their data/ctrl registers cleared to 0. Outputs: out_valid=0, out_data=0, out_ctrl=0, count=0, stall_cnt=0, in_ready=1. Reset mid-transfer drops every entry with no partial state.
- Handshake: input beat transfers at a falling edge when in_valid=1 and in_ready=1. Output beat transfers when out_valid=1 and out_ready=1.
- Latency: an accepted entry appears on out_* immediately after the capturing falling edge (1 edge), provided the head slot is empty or draining.
- Ordering: strictly FIFO. Data and ctrl of an entry are never mixed across entries.
- SKID=1, two registers head(H) and skid(S):
  - in_ready = !S.valid (registered, no combinational path from out_ready).
  - H empty or H draining: H loads S if S valid, else the input beat if transferring. S loads the input beat if S was the source and an input beat transfers, otherwise S becomes empty.
  - H held (valid, not draining) and input beat transfers: the beat goes to S.
  - Simultaneous drain and input with S full is impossible, because in_ready=0.
- SKID=0, single register H:
  - in_ready = !H.valid | out_ready (combinational).
  - H loads the input on transfer; otherwise it clears on drain.
- out_ctrl = H.valid ? H.ctrl : 0. out_data holds its last value when invalid.
- Flush, synchronous at the falling edge:
  - All entries invalid and count=0 after the edge.
  - Flush overrides any input beat transferring at that edge. The beat is dropped, and upstream treats it as consumed.
  - Any output beat transferring at the same edge is still considered delivered.
- stall_cnt increments by 1 at each falling edge where out_valid=1 and out_ready=0, flush included. It saturates at 2^CNT_W-1 and is cleared only by rst.
- count = H.valid + S.valid.

Test Plan:
- Reset then stream: rst pulse, out_ready=1, push in_data=0x00000010..0x00000013 with in_ctrl=0x05 on consecutive edges -> out_data sequence 0x10,0x11,0x12,0x13, each one edge after capture; out_ctrl=0x05 when valid, 0x00 otherwise; count stays 1.
- Backpressure with SKID=1: out_ready=0, push A=0xAAAA0000 then B=0xBBBB0000 -> count=2, in_ready=0 after the second edge, out_data=A. Then out_ready=1 -> A, then B delivered, and in_ready=1 one edge after A drains.
- Flush collision: count=2, flush=1 together with in_valid=1 (C=0xCCCC0000) -> after the edge, count=0, out_valid=0, out_ctrl=0. C never appears at the output.
- Stall counter: hold out_valid=1 with out_ready=0 for 5 edges, CNT_W=3 variant for 10 edges -> stall_cnt=5, and 7 (saturated) respectively.
- Async reset mid-operation: count=2, assert rst between edges -> outputs clear immediately without a clock edge. First beat after deassert is accepted normally.
- SKID=0: out_ready=0 with H valid -> in_ready=0 combinationally. Raising out_ready -> in_ready=1 in the same cycle, and simultaneous drain and load at the next edge.
